// File: rtl/bcd_seg_display.sv
// Binary-to-seven-segment display stage: a bit-serial double-dabble engine feeds
// registered active-low HEX outputs, with overflow dashes and optional leading-zero blanking.
module bcd_seg_display #(
  parameter int WIDTH         = 10,
  parameter int DIGITS        = 4,
  parameter int BLANK_LEADING = 1
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [WIDTH-1:0] bin,
  output logic [7:0]       hex0,
  output logic [7:0]       hex1,
  output logic [7:0]       hex2,
  output logic [7:0]       hex3,
  output logic [7:0]       hex4,
  output logic [7:0]       hex5,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] LATCH = 2'd2;

  localparam int CW = $clog2(WIDTH);

  logic [1:0]       state;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] last;
  logic [27:0]      bcd;
  logic [23:0]      bcd_adj;
  logic [CW-1:0]    cnt;
  logic             vld;
  logic [5:0][7:0]  hex;
  logic [5:0][7:0]  seg;
  logic [5:0]       lead_zero;
  logic             run_zero;
  logic             ovf;

  function automatic logic [7:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0:    digit_seg = 8'hC0;
      4'd1:    digit_seg = 8'hF9;
      4'd2:    digit_seg = 8'hA4;
      4'd3:    digit_seg = 8'hB0;
      4'd4:    digit_seg = 8'h99;
      4'd5:    digit_seg = 8'h92;
      4'd6:    digit_seg = 8'h82;
      4'd7:    digit_seg = 8'hF8;
      4'd8:    digit_seg = 8'h80;
      4'd9:    digit_seg = 8'h90;
      default: digit_seg = 8'hFF;
    endcase
  endfunction

  // The top nibble never reaches 5 for WIDTH <= 20, so it shifts without adjustment.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd[gi*4 +: 4] >= 4'd5) ? bcd[gi*4 +: 4] + 4'd3
                                                            : bcd[gi*4 +: 4];
    end
  endgenerate

  always_comb begin
    ovf = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i >= DIGITS) ovf = ovf | (bcd[i*4 +: 4] != 4'd0);
    end
  end

  // lead_zero[i]: digit i and every higher active digit are zero.
  always_comb begin
    run_zero  = 1'b1;
    lead_zero = '0;
    for (int i = 5; i >= 0; i--) begin
      if (i < DIGITS) run_zero = run_zero & (bcd[i*4 +: 4] == 4'd0);
      lead_zero[i] = run_zero;
    end
  end

  always_comb begin
    seg = '1;
    for (int i = 0; i < 6; i++) begin
      if (i >= DIGITS)                                  seg[i] = 8'hFF;
      else if (ovf)                                     seg[i] = 8'hBF;
      else if (BLANK_LEADING != 0 && i >= 1 && lead_zero[i]) seg[i] = 8'hFF;
      else                                              seg[i] = digit_seg(bcd[i*4 +: 4]);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      sh    <= '0;
      last  <= '0;
      bcd   <= '0;
      cnt   <= '0;
      vld   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hex   <= '1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (!vld || bin != last) begin
            sh    <= bin;
            last  <= bin;
            vld   <= 1'b1;
            bcd   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          bcd <= {bcd[26:24], bcd_adj, sh[WIDTH-1]};
          sh  <= {sh[WIDTH-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= LATCH;
        end
        LATCH: begin
          hex   <= seg;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign hex0 = hex[0];
  assign hex1 = hex[1];
  assign hex2 = hex[2];
  assign hex3 = hex[3];
  assign hex4 = hex[4];
  assign hex5 = hex[5];

endmodule

// File: doc/bcd_seg_display.md
# bcd_seg_display

Downstream display stage for the DE10-Lite binary counter. Converts the counter's binary output `q` into decimal digits with a sequential double-dabble (shift-add-3) engine, one bit per clock. Drives the board's active-low seven-segment displays HEX0..HEX5 from registered outputs. Values that do not fit in the configured digits are shown as dashes.

## Interface
- `WIDTH`, default 10: binary input width; legal range 4..20.
- `DIGITS`, default 4: number of active displays starting at HEX0; legal range 1..6.
- `BLANK_LEADING`, default 1: when 1, leading zeros are blanked; HEX0 is always lit.
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `clrn`, input, 1: asynchronous, active-low reset.
- `bin`, input, WIDTH: binary value, normally the counter's `q`.
- `hex0`..`hex5`, output, 8 each: segments `{dp,g,f,e,d,c,b,a}`, active-low.
- `busy`, output, 1: high while a conversion is in flight.
- `done`, output, 1: one-cycle pulse on the cycle the hex outputs update.

## Operation
- Internal state:
  - `sh`: WIDTH-bit shift register.
  - `bcd`: 7 nibbles, enough for 2^20−1.
  - `cnt`: shift counter.
  - `last`: captured value, WIDTH bits.
  - `vld`: 1 bit; set on the first capture after reset.
  - FSM: IDLE, SHIFT, LATCH.
- IDLE: if `!vld` or `bin != last`, capture in one edge: `sh<=bin`, `last<=bin`, `vld<=1`, `bcd<=0`, `cnt<=0`, `busy<=1`, state SHIFT. Otherwise hold.
- SHIFT, each edge:
  - Every nibble ≥5 gets +3.
  - `{bcd,sh}` shifts left by 1.
  - `cnt<=cnt+1`.
  - On the edge where `cnt==WIDTH-1`, go to LATCH. Exactly WIDTH shifts occur.
- LATCH, one edge:
  - Decode `bcd` into the hex registers.
  - `done<=1` for this one cycle; `busy<=0`; state IDLE.
- `bin` is sampled only at capture. Changes during SHIFT/LATCH are ignored. The next IDLE cycle compares `bin` against `last` and re-converts if they differ. The counter's intermediate values may be skipped; the final value is always shown.
- Digit encoding, active-low hex:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Blank = FF. Dash = BF (segment g only).
- The dp bit is always 1 (off).
- Overflow: if any BCD nibble at index ≥ DIGITS is nonzero, all active displays show dash.
- Leading blanking (BLANK_LEADING=1, no overflow): digit i ≥ 1 is blank if it and all higher active digits are zero. The value 0 shows a single "0" on HEX0.
- Displays with index ≥ DIGITS are always FF.
- Hex outputs change only on the LATCH edge (or on reset). No glitching through partial BCD states.

## Timing
- Reset (`clrn`=0, asynchronous):
  - `hex0`..`hex5` = FF, `busy`=0, `done`=0.
  - `vld`=0, `last`=0, `bcd`=0, `cnt`=0, state IDLE.
- First rising edge after `clrn` deasserts: capture occurs (since `vld`=0).
- Latency from capture edge E0:
  - Shifts on E1..E_WIDTH.
  - Outputs and `done` valid after E_(WIDTH+1).
  - Total WIDTH+2 edges from IDLE sampling to display update; 12 with the defaults.
- `busy` rises after E0 and falls after E_(WIDTH+1), coincident with `done` high. `done` drops on the next edge.
- Back-to-back: if `bin` already differs from `last` when IDLE is re-entered, the new capture happens on the next edge. The minimum period between `done` pulses is WIDTH+2 cycles.
- Reset mid-conversion: aborts immediately. Outputs return to FF; a fresh conversion starts after release.
- Sustained throughput suits a counter clocked from a debounced push-button, or any rate below clk/(WIDTH+2).

## Test plan
- Reset, then `bin`=0, defaults → after 12 edges `done` pulses; hex0=C0, hex1..hex5=FF; `busy` high for exactly 11 cycles.
- `bin`=1023, defaults → hex3..hex0 = F9,C0,A4,B0; hex4, hex5 = FF.
- `bin`=5 then `bin`=40, BLANK_LEADING=1 → first "5": hex0=92, others FF. Then "40": hex1=99, hex0=C0.
- `bin`=7 and, 3 cycles into SHIFT, `bin`=8 → first `done` shows F8. A second conversion starts the cycle after. The second `done` arrives 12 edges later and shows 80.
- WIDTH=10, DIGITS=2, `bin`=100 → hex1=hex0=BF; hex2..hex5=FF.
- `bin`=999; pull `clrn` low mid-SHIFT → all hex immediately FF, `busy`=0. After release, hex2..hex0=90,90,90 following 12 edges.
